// File: rtl/vm_pkg.sv
// Shared types for the change dispenser: coin codes, coin values and controller states.
package vm_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10,
        COIN_25   = 2'b11
    } coin_t;

    localparam logic [15:0] VAL_5  = 16'd5;
    localparam logic [15:0] VAL_10 = 16'd10;
    localparam logic [15:0] VAL_25 = 16'd25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_DISPENSE,
        ST_DONE,
        ST_ERROR
    } state_t;

    function automatic logic [15:0] coin_value(input coin_t c);
        case (c)
            COIN_5:  coin_value = VAL_5;
            COIN_10: coin_value = VAL_10;
            COIN_25: coin_value = VAL_25;
            default: coin_value = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_coin_inventory.sv
// 8-bit coin inventory: saturating add of a refill count and a single-coin decrement,
// both allowed in the same cycle.
module vm_coin_inventory (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic [7:0] inc_cnt,
    input  logic       dec,
    output logic [7:0] count
);

    logic [8:0] sum;
    logic [7:0] count_nxt;

    // Decrement is applied before saturation so 255 - 1 + 1 stays at 255.
    always_comb begin
        sum = {1'b0, count} + (inc ? {1'b0, inc_cnt} : 9'd0);
        if (dec && sum != 9'd0)
            sum = sum - 9'd1;
        count_nxt = sum[8] ? 8'hFF : sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 8'd0;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/vm_change_dispenser.sv
// Change dispenser controller: pays out an amount greedily from three coin inventories,
// one coin per hopper handshake.
//
// state       | meaning
// ST_IDLE     | waiting for start
// ST_SELECT   | choose largest payable coin, or finish / fail
// ST_DISPENSE | coin presented, waiting for coin_ack
// ST_DONE     | one-cycle done pulse
// ST_ERROR    | residue cannot be paid, error held
module vm_change_dispenser
    import vm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] amount,
    output logic [1:0]  coin_out,
    output logic        coin_out_valid,
    input  logic        coin_ack,
    input  logic        refill,
    input  logic [1:0]  refill_sel,
    input  logic [7:0]  refill_cnt,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] remaining
);

    state_t     state;
    coin_t      cur_coin;
    coin_t      pick;
    logic [7:0] inv_5;
    logic [7:0] inv_10;
    logic [7:0] inv_25;
    logic       ack_take;

    assign coin_out = cur_coin;
    assign ack_take = (state == ST_DISPENSE) && coin_ack;

    vm_coin_inventory u_inv_5 (
        .clk     (clk),
        .rst     (rst),
        .inc     (refill && refill_sel == COIN_5),
        .inc_cnt (refill_cnt),
        .dec     (ack_take && cur_coin == COIN_5),
        .count   (inv_5)
    );

    vm_coin_inventory u_inv_10 (
        .clk     (clk),
        .rst     (rst),
        .inc     (refill && refill_sel == COIN_10),
        .inc_cnt (refill_cnt),
        .dec     (ack_take && cur_coin == COIN_10),
        .count   (inv_10)
    );

    vm_coin_inventory u_inv_25 (
        .clk     (clk),
        .rst     (rst),
        .inc     (refill && refill_sel == COIN_25),
        .inc_cnt (refill_cnt),
        .dec     (ack_take && cur_coin == COIN_25),
        .count   (inv_25)
    );

    always_comb begin
        pick = COIN_NONE;
        if (remaining >= VAL_25 && inv_25 != 8'd0)
            pick = COIN_25;
        else if (remaining >= VAL_10 && inv_10 != 8'd0)
            pick = COIN_10;
        else if (remaining >= VAL_5 && inv_5 != 8'd0)
            pick = COIN_5;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cur_coin       <= COIN_NONE;
            coin_out_valid <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            remaining      <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        remaining <= amount;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SELECT;
                    end else if (state == ST_DONE) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    if (remaining == 16'd0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else if (pick != COIN_NONE) begin
                        cur_coin       <= pick;
                        coin_out_valid <= 1'b1;
                        state          <= ST_DISPENSE;
                    end else begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_ERROR;
                    end
                end
                ST_DISPENSE: begin
                    if (coin_ack) begin
                        remaining      <= remaining - coin_value(cur_coin);
                        cur_coin       <= COIN_NONE;
                        coin_out_valid <= 1'b0;
                        state          <= ST_SELECT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser: greedy payout, shortfall error, zero amount,
// stalled hopper with reset, and inventory saturation.
module tb_vm_change_dispenser;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] amount;
    logic [1:0]  coin_out;
    logic        coin_out_valid;
    logic        coin_ack;
    logic        refill;
    logic [1:0]  refill_sel;
    logic [7:0]  refill_cnt;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] remaining;

    int n_cmp = 0;
    int n_err = 0;

    vm_change_dispenser dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .amount         (amount),
        .coin_out       (coin_out),
        .coin_out_valid (coin_out_valid),
        .coin_ack       (coin_ack),
        .refill         (refill),
        .refill_sel     (refill_sel),
        .refill_cnt     (refill_cnt),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .remaining      (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_refill(input logic [1:0] sel, input logic [7:0] cnt);
        refill     = 1'b1;
        refill_sel = sel;
        refill_cnt = cnt;
        tick();
        refill     = 1'b0;
        refill_sel = 2'b00;
        refill_cnt = 8'd0;
    endtask

    task automatic do_start(input logic [15:0] amt);
        start  = 1'b1;
        amount = amt;
        tick();
        start  = 1'b0;
    endtask

    task automatic expect_coin(input string tag, input logic [1:0] code);
        for (int i = 0; i < 8 && !coin_out_valid; i++) tick();
        chk({tag, "_valid"}, coin_out_valid, 1);
        chk({tag, "_code"}, coin_out, code);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 10 && !(done || error); i++) tick();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        amount     = 16'd0;
        coin_ack   = 1'b0;
        refill     = 1'b0;
        refill_sel = 2'b00;
        refill_cnt = 8'd0;
        #1;
        chk("rst_valid", coin_out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_remaining", remaining, 0);
        tick();
        rst = 1'b0;

        // 40c with 4 of each coin: 25, 10, 5 at two-cycle spacing
        do_refill(2'b01, 8'd4);
        do_refill(2'b10, 8'd4);
        do_refill(2'b11, 8'd4);
        do_refill(2'b00, 8'd9);
        chk("refill_inv5", dut.inv_5, 4);
        chk("refill_inv10", dut.inv_10, 4);
        chk("refill_inv25", dut.inv_25, 4);
        do_start(16'd40);
        chk("t1_busy", busy, 1);
        chk("t1_early_valid", coin_out_valid, 0);
        tick();
        chk("t1_c1_valid", coin_out_valid, 1);
        chk("t1_c1_code", coin_out, 3);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        chk("t1_gap_valid", coin_out_valid, 0);
        chk("t1_rem15", remaining, 15);
        tick();
        chk("t1_c2_valid", coin_out_valid, 1);
        chk("t1_c2_code", coin_out, 2);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        chk("t1_rem5", remaining, 5);
        tick();
        chk("t1_c3_valid", coin_out_valid, 1);
        chk("t1_c3_code", coin_out, 1);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        chk("t1_pre_done", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_rem0", remaining, 0);
        chk("t1_inv25", dut.inv_25, 3);
        chk("t1_inv10", dut.inv_10, 3);
        chk("t1_inv5", dut.inv_5, 3);
        tick();
        chk("t1_done_pulse", done, 0);

        // 30c with no quarters, one dime, five nickels
        do_reset();
        do_refill(2'b10, 8'd1);
        do_refill(2'b01, 8'd5);
        do_start(16'd30);
        expect_coin("t2_c1", 2'b10);
        expect_coin("t2_c2", 2'b01);
        expect_coin("t2_c3", 2'b01);
        expect_coin("t2_c4", 2'b01);
        expect_coin("t2_c5", 2'b01);
        wait_end();
        chk("t2_done", done, 1);
        chk("t2_error", error, 0);
        chk("t2_inv5", dut.inv_5, 1);
        chk("t2_inv10", dut.inv_10, 0);

        // 15c with only one nickel: pays 5, fails with 10 owed
        do_reset();
        do_refill(2'b01, 8'd1);
        do_start(16'd15);
        expect_coin("t3_c1", 2'b01);
        wait_end();
        chk("t3_error", error, 1);
        chk("t3_remaining", remaining, 10);
        chk("t3_busy", busy, 0);
        chk("t3_done", done, 0);
        coin_ack = 1'b1;
        tick();
        tick();
        coin_ack = 1'b0;
        chk("t3_error_sticky", error, 1);
        chk("t3_ack_ignored", remaining, 10);

        // zero amount from ERROR: clears error, no coin, done after two edges
        do_start(16'd0);
        chk("t4_err_clr", error, 0);
        chk("t4_valid_a", coin_out_valid, 0);
        chk("t4_done_early", done, 0);
        tick();
        chk("t4_valid_b", coin_out_valid, 0);
        chk("t4_done", done, 1);
        tick();
        chk("t4_done_pulse", done, 0);

        // stalled hopper, start ignored mid-dispense, then reset
        do_refill(2'b11, 8'd2);
        do_start(16'd25);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                start  = 1'b1;
                amount = 16'd99;
            end
            tick();
            start = 1'b0;
            chk("t5_hold_valid", coin_out_valid, 1);
            chk("t5_hold_code", coin_out, 3);
        end
        chk("t5_rem_held", remaining, 25);
        chk("t5_inv25_held", dut.inv_25, 2);
        chk("t5_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", coin_out_valid, 0);
        chk("t5_rst_code", coin_out, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_error", error, 0);
        chk("t5_rst_rem", remaining, 0);
        chk("t5_rst_inv25", dut.inv_25, 0);
        tick();
        rst = 1'b0;

        // saturation and simultaneous refill with ack
        do_refill(2'b01, 8'd10);
        chk("t6_inv5_10", dut.inv_5, 10);
        do_refill(2'b01, 8'd255);
        chk("t6_inv5_sat", dut.inv_5, 255);
        do_start(16'd5);
        tick();
        chk("t6_code", coin_out, 1);
        coin_ack   = 1'b1;
        refill     = 1'b1;
        refill_sel = 2'b01;
        refill_cnt = 8'd1;
        tick();
        coin_ack   = 1'b0;
        refill     = 1'b0;
        refill_sel = 2'b00;
        refill_cnt = 8'd0;
        chk("t6_inv5_ackrefill", dut.inv_5, 255);
        wait_end();
        chk("t6_done", done, 1);

        do_refill(2'b10, 8'd3);
        do_start(16'd10);
        tick();
        chk("t7_code", coin_out, 2);
        coin_ack   = 1'b1;
        refill     = 1'b1;
        refill_sel = 2'b10;
        refill_cnt = 8'd2;
        tick();
        coin_ack   = 1'b0;
        refill     = 1'b0;
        refill_sel = 2'b00;
        refill_cnt = 8'd0;
        chk("t7_inv10", dut.inv_10, 4);
        wait_end();
        chk("t7_done", done, 1);
        tick();
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        chk("t7_idle_ack_inv10", dut.inv_10, 4);
        chk("t7_idle_ack_valid", coin_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
